// File: rtl/am2901_pkg.sv
// Decode types and constants for the am2901_wide bit-slice.
package am2901_pkg;

    localparam int INSTR_W = 9;

    typedef enum logic [2:0] {
        SRC_AQ, SRC_AB, SRC_ZQ, SRC_ZB, SRC_ZA, SRC_DA, SRC_DQ, SRC_DZ
    } src_e;

    typedef enum logic [2:0] {
        FN_ADD, FN_SUBR, FN_SUBS, FN_OR, FN_AND, FN_NOTRS, FN_XOR, FN_XNOR
    } fn_e;

    typedef enum logic [2:0] {
        DST_QREG, DST_NOP, DST_RAMA, DST_RAMF, DST_RAMQD, DST_RAMD, DST_RAMQU, DST_RAMU
    } dst_e;

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } mul_state_e;

    function automatic logic is_arith(input fn_e fn);
        return (fn == FN_ADD) || (fn == FN_SUBR) || (fn == FN_SUBS);
    endfunction

endpackage

// File: rtl/am2901_wide_if.sv
// Microinstruction, data, neighbour-chaining and multiply handshake pins of one slice.
interface am2901_wide_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
);
    logic [8:0]       i;
    logic [AW-1:0]    a;
    logic [AW-1:0]    b;
    logic [WIDTH-1:0] d;
    logic             cin;
    logic             oe;
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             g_lo;
    logic             p_lo;
    logic             ovr;
    logic             z;
    logic             fmsb;
    logic             ram_lsb_i;
    logic             ram_msb_i;
    logic             q_lsb_i;
    logic             q_msb_i;
    logic             ram_lsb_o;
    logic             ram_msb_o;
    logic             q_lsb_o;
    logic             q_msb_o;
    logic             shift_dn;
    logic             shift_up;
    logic             start;
    logic             busy;
    logic             done;

    modport master (
        output i, a, b, d, cin, oe, ram_lsb_i, ram_msb_i, q_lsb_i, q_msb_i, start,
        input  y, cout, g_lo, p_lo, ovr, z, fmsb, ram_lsb_o, ram_msb_o, q_lsb_o, q_msb_o,
               shift_dn, shift_up, busy, done
    );

    modport slave (
        input  i, a, b, d, cin, oe, ram_lsb_i, ram_msb_i, q_lsb_i, q_msb_i, start,
        output y, cout, g_lo, p_lo, ovr, z, fmsb, ram_lsb_o, ram_msb_o, q_lsb_o, q_msb_o,
               shift_dn, shift_up, busy, done
    );
endinterface

// File: rtl/am2901_alu.sv
// WIDTH-bit Am2901 ALU: F, carry, overflow and active-low lookahead terms.
// Latency: purely combinational.
// Backpressure: none; outputs follow operands and function immediately.
module am2901_alu
    import am2901_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] s,
    input  logic             cin,
    input  fn_e              fn,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             ovr,
    output logic             g_lo,
    output logic             p_lo
);
    logic [WIDTH-1:0] ra, sa, pv, gv, lr, lp, lg;
    logic [WIDTH:0]   sum;
    logic             gen, lgen;

    always_comb begin
        ra   = (fn == FN_SUBR) ? ~r : r;
        sa   = (fn == FN_SUBS) ? ~s : s;
        sum  = {1'b0, ra} + {1'b0, sa} + {{WIDTH{1'b0}}, cin};
        pv   = ra | sa;
        gv   = ra & sa;
        lr   = (fn == FN_XOR) ? ~r : r;
        lp   = lr | s;
        lg   = lr & s;
        gen  = 1'b0;
        lgen = lp[0];
        // group generate is the slice carry-out with carry-in held at 0
        for (int k = 0; k < WIDTH; k++) gen = gv[k] | (pv[k] & gen);
        for (int k = 1; k < WIDTH; k++) lgen = lg[k] | (lp[k] & lgen);
        f    = sum[WIDTH-1:0];
        cout = sum[WIDTH];
        ovr  = sum[WIDTH] ^ ra[WIDTH-1] ^ sa[WIDTH-1] ^ sum[WIDTH-1];
        g_lo = ~gen;
        p_lo = ~&pv;
        if (!is_arith(fn)) begin
            cout = 1'b0;
            ovr  = 1'b0;
            p_lo = 1'b0;
            case (fn)
                FN_OR:    begin f = r | s;     g_lo = &(r | s);   end
                FN_AND:   begin f = r & s;     g_lo = ~|(r & s);  end
                FN_NOTRS: begin f = ~r & s;    g_lo = ~|(~r & s); end
                FN_XOR:   begin f = r ^ s;     p_lo = |lg; g_lo = lgen; end
                FN_XNOR:  begin f = ~(r ^ s);  p_lo = |lg; g_lo = lgen; end
                default:  ;
            endcase
        end
    end
endmodule

// File: rtl/am2901_wide.sv
// WIDTH-bit Am2901 slice with register file, Q, shifters and shift-add multiply sequencer.
// Latency: outputs combinational; state on rising cp; multiply result written WIDTH cycles after start.
// Backpressure: start ignored while busy; instruction writes to RAM/Q suppressed while busy.
module am2901_wide
    import am2901_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input logic          cp,
    input logic          rst_lo,
    am2901_wide_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] ram [DEPTH];
    logic [WIDTH-1:0] q_reg, a_dat, b_dat, r, s, f, ram_wdat, q_wdat;
    logic             ram_we, q_we, cout, ovr, g_lo, p_lo;
    src_e             src;
    dst_e             dst;

    mul_state_e       state, state_n;
    logic [AW-1:0]    b_lat;
    logic [WIDTH-1:0] mcand, mq, acc, acc_n, mq_n;
    logic [WIDTH:0]   mul_sum;
    logic [CW-1:0]    cnt;
    logic             mul_last, done_q;

    assign src   = src_e'(bus.i[2:0]);
    assign dst   = dst_e'(bus.i[8:6]);
    assign a_dat = ram[bus.a];
    assign b_dat = ram[bus.b];

    always_comb begin
        r = '0;
        s = '0;
        case (src)
            SRC_AQ: begin r = a_dat; s = q_reg; end
            SRC_AB: begin r = a_dat; s = b_dat; end
            SRC_ZQ: s = q_reg;
            SRC_ZB: s = b_dat;
            SRC_ZA: s = a_dat;
            SRC_DA: begin r = bus.d; s = a_dat; end
            SRC_DQ: begin r = bus.d; s = q_reg; end
            SRC_DZ: r = bus.d;
            default: ;
        endcase
    end

    am2901_alu #(.WIDTH(WIDTH)) u_alu (
        .r    (r),
        .s    (s),
        .cin  (bus.cin),
        .fn   (fn_e'(bus.i[5:3])),
        .f    (f),
        .cout (cout),
        .ovr  (ovr),
        .g_lo (g_lo),
        .p_lo (p_lo)
    );

    always_comb begin
        ram_we   = 1'b0;
        q_we     = 1'b0;
        ram_wdat = f;
        q_wdat   = f;
        case (dst)
            DST_QREG:  q_we = 1'b1;
            DST_RAMA,
            DST_RAMF:  ram_we = 1'b1;
            DST_RAMQD: begin
                ram_we = 1'b1; q_we = 1'b1;
                ram_wdat = {bus.ram_msb_i, f[WIDTH-1:1]};
                q_wdat   = {bus.q_msb_i, q_reg[WIDTH-1:1]};
            end
            DST_RAMD:  begin ram_we = 1'b1; ram_wdat = {bus.ram_msb_i, f[WIDTH-1:1]}; end
            DST_RAMQU: begin
                ram_we = 1'b1; q_we = 1'b1;
                ram_wdat = {f[WIDTH-2:0], bus.ram_lsb_i};
                q_wdat   = {q_reg[WIDTH-2:0], bus.q_lsb_i};
            end
            DST_RAMU:  begin ram_we = 1'b1; ram_wdat = {f[WIDTH-2:0], bus.ram_lsb_i}; end
            default:   ;
        endcase
    end

    assign bus.y         = bus.oe ? ((dst == DST_RAMA) ? a_dat : f) : '0;
    assign bus.cout      = cout;
    assign bus.ovr       = ovr;
    assign bus.g_lo      = g_lo;
    assign bus.p_lo      = p_lo;
    assign bus.z         = (f == '0);
    assign bus.fmsb      = f[WIDTH-1];
    assign bus.ram_lsb_o = f[0];
    assign bus.ram_msb_o = f[WIDTH-1];
    assign bus.q_lsb_o   = q_reg[0];
    assign bus.q_msb_o   = q_reg[WIDTH-1];
    assign bus.shift_dn  = (dst == DST_RAMQD) || (dst == DST_RAMD);
    assign bus.shift_up  = (dst == DST_RAMQU) || (dst == DST_RAMU);
    assign bus.busy      = (state == ST_MUL);
    assign bus.done      = done_q;

    always_ff @(posedge cp or negedge rst_lo) begin
        if (!rst_lo) state <= ST_IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n  = state;
        mul_last = 1'b0;
        case (state)
            ST_IDLE: if (bus.start) state_n = ST_MUL;
            ST_MUL:  if (cnt == CW'(WIDTH - 1)) begin
                state_n  = ST_IDLE;
                mul_last = 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // one shift-add step; acc stays below 2^WIDTH after the shift so WIDTH bits hold it
    assign mul_sum = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
    assign acc_n   = mul_sum[WIDTH:1];
    assign mq_n    = {mul_sum[0], mq[WIDTH-1:1]};

    always_ff @(posedge cp or negedge rst_lo) begin
        if (!rst_lo) begin
            for (int k = 0; k < DEPTH; k++) ram[k] <= '0;
            q_reg  <= '0;
            b_lat  <= '0;
            mcand  <= '0;
            mq     <= '0;
            acc    <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= mul_last;
            if (state == ST_IDLE) begin
                if (ram_we) ram[bus.b] <= ram_wdat;
                if (q_we)   q_reg <= q_wdat;
                if (bus.start) begin
                    b_lat <= bus.b;
                    mcand <= a_dat;
                    mq    <= q_reg;
                    acc   <= '0;
                    cnt   <= '0;
                end
            end else begin
                acc <= acc_n;
                mq  <= mq_n;
                cnt <= cnt + 1'b1;
                if (mul_last) begin
                    ram[b_lat] <= acc_n;
                    q_reg      <= mq_n;
                end
            end
        end
    end
endmodule

// File: tb/tb_am2901_wide.sv
// Bench for am2901_wide: directed scenarios plus random microinstructions against a cycle model.
module tb_am2901_wide;
    localparam int W     = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    localparam logic [8:0] RD_A = {3'd1, 3'd3, 3'd4};
    localparam logic [8:0] RD_Q = {3'd1, 3'd3, 3'd2};
    localparam logic [8:0] LD_B = {3'd3, 3'd0, 3'd7};
    localparam logic [8:0] LD_Q = {3'd0, 3'd0, 3'd7};

    logic cp = 1'b0;
    logic rst_lo = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    int mram [DEPTH];
    int mq_m, m_left, m_done, mul_a, mul_q, mul_b;

    am2901_wide_if #(.WIDTH(W), .AW(AW)) bus ();
    am2901_wide #(.WIDTH(W), .DEPTH(DEPTH)) dut (.cp(cp), .rst_lo(rst_lo), .bus(bus));

    always #5 cp = ~cp;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input int v);
        return (v > 127) ? v - 256 : v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) mram[k] = 0;
        mq_m = 0; m_left = 0; m_done = 0;
    endtask

    // one cycle: drive at negedge, check outputs, then advance model across the next rising edge
    task automatic op_check(input logic [8:0] ins, input int av, input int bv, input int dv,
                            input logic cv, input logic [3:0] fl, input logic oev, input logic st);
        int r, s, ro, so, f, co, ov, gl, pl, yv, ssum, prod;
        int src, fn, dst;
        @(negedge cp);
        bus.i = ins; bus.a = av[AW-1:0]; bus.b = bv[AW-1:0]; bus.d = dv[W-1:0];
        bus.cin = cv; bus.oe = oev; bus.start = st;
        bus.ram_msb_i = fl[3]; bus.ram_lsb_i = fl[2]; bus.q_msb_i = fl[1]; bus.q_lsb_i = fl[0];
        #1;
        src = int'(ins[2:0]); fn = int'(ins[5:3]); dst = int'(ins[8:6]);
        case (src)
            0: begin r = mram[av]; s = mq_m; end
            1: begin r = mram[av]; s = mram[bv]; end
            2: begin r = 0; s = mq_m; end
            3: begin r = 0; s = mram[bv]; end
            4: begin r = 0; s = mram[av]; end
            5: begin r = dv; s = mram[av]; end
            6: begin r = dv; s = mq_m; end
            default: begin r = dv; s = 0; end
        endcase
        ro = r; so = s; gl = -1; pl = -1;
        if (fn == 1) ro = ~r & 255;
        if (fn == 2) so = ~s & 255;
        if (fn <= 2) begin
            f    = (ro + so + int'(cv)) & 255;
            co   = (ro + so + int'(cv)) >> 8;
            ssum = sx(ro) + sx(so) + int'(cv);
            ov   = (ssum > 127 || ssum < -128) ? 1 : 0;
            gl   = (ro + so > 255) ? 0 : 1;
            pl   = ((ro | so) == 255) ? 0 : 1;
        end else begin
            co = 0; ov = 0;
            case (fn)
                3: f = r | s;
                4: f = r & s;
                5: f = ~r & s;
                6: f = r ^ s;
                default: f = ~(r ^ s) & 255;
            endcase
        end
        yv = oev ? ((dst == 2) ? mram[av] : f) : 0;
        chk("y", 32'(bus.y), yv);
        chk("cout", 32'(bus.cout), co);
        chk("ovr", 32'(bus.ovr), ov);
        chk("z", 32'(bus.z), (f == 0) ? 1 : 0);
        chk("fmsb", 32'(bus.fmsb), f >> 7);
        if (gl >= 0) begin
            chk("g_lo", 32'(bus.g_lo), gl);
            chk("p_lo", 32'(bus.p_lo), pl);
        end
        chk("shift_dn", 32'(bus.shift_dn), (dst == 4 || dst == 5) ? 1 : 0);
        chk("shift_up", 32'(bus.shift_up), (dst == 6 || dst == 7) ? 1 : 0);
        chk("ram_lsb_o", 32'(bus.ram_lsb_o), f & 1);
        chk("ram_msb_o", 32'(bus.ram_msb_o), f >> 7);
        chk("q_lsb_o", 32'(bus.q_lsb_o), mq_m & 1);
        chk("q_msb_o", 32'(bus.q_msb_o), mq_m >> 7);
        chk("busy", 32'(bus.busy), (m_left > 0) ? 1 : 0);
        chk("done", 32'(bus.done), m_done);
        if (m_left > 0) begin
            m_left--;
            m_done = 0;
            if (m_left == 0) begin
                prod = mul_a * mul_q;
                mram[mul_b] = prod >> 8;
                mq_m = prod & 255;
                m_done = 1;
            end
        end else begin
            m_done = 0;
            if (st) begin
                mul_a = mram[av]; mul_q = mq_m; mul_b = bv; m_left = W;
            end
            case (dst)
                0: mq_m = f;
                2, 3: mram[bv] = f;
                4: begin
                    mram[bv] = (f >> 1) | (int'(fl[3]) << 7);
                    mq_m = (mq_m >> 1) | (int'(fl[1]) << 7);
                end
                5: mram[bv] = (f >> 1) | (int'(fl[3]) << 7);
                6: begin
                    mram[bv] = ((f << 1) & 255) | int'(fl[2]);
                    mq_m = ((mq_m << 1) & 255) | int'(fl[0]);
                end
                7: mram[bv] = ((f << 1) & 255) | int'(fl[2]);
                default: ;
            endcase
        end
    endtask

    initial begin
        int ra, rb;
        model_reset();
        bus.i = RD_Q; bus.a = '0; bus.b = '0; bus.d = '0; bus.cin = 1'b0; bus.oe = 1'b1;
        bus.start = 1'b0; bus.ram_msb_i = 1'b0; bus.ram_lsb_i = 1'b0;
        bus.q_msb_i = 1'b0; bus.q_lsb_i = 1'b0;
        repeat (2) @(negedge cp);
        rst_lo = 1'b1;

        op_check(RD_Q, 0, 0, 0, 1'b0, 4'h0, 1'b1, 1'b0);
        chk("rst_q", 32'(bus.y), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        op_check(RD_A, 9, 0, 0, 1'b0, 4'h0, 1'b1, 1'b0);
        chk("rst_ram9", 32'(bus.y), 0);

        op_check(LD_B, 0, 3, 'h5A, 1'b0, 4'h0, 1'b1, 1'b0);
        chk("ld_y", 32'(bus.y), 'h5A);
        chk("ld_z", 32'(bus.z), 0);
        op_check(RD_A, 3, 0, 0, 1'b0, 4'h0, 1'b1, 1'b0);
        chk("ram3", 32'(bus.y), 'h5A);

        op_check(LD_B, 0, 1, 'h7F, 1'b0, 4'h0, 1'b1, 1'b0);
        op_check(LD_B, 0, 2, 'h01, 1'b0, 4'h0, 1'b1, 1'b0);
        op_check({3'd1, 3'd0, 3'd1}, 1, 2, 0, 1'b0, 4'h0, 1'b1, 1'b0);
        chk("add_f", 32'(bus.y), 'h80);
        chk("add_ovr", 32'(bus.ovr), 1);
        chk("add_cout", 32'(bus.cout), 0);
        chk("add_fmsb", 32'(bus.fmsb), 1);
        op_check({3'd1, 3'd1, 3'd1}, 1, 1, 0, 1'b1, 4'h0, 1'b1, 1'b0);
        chk("sub_z", 32'(bus.z), 1);
        chk("sub_cout", 32'(bus.cout), 1);

        op_check(LD_Q, 0, 0, 'h02, 1'b0, 4'h0, 1'b1, 1'b0);
        op_check({3'd4, 3'd0, 3'd7}, 0, 6, 'h81, 1'b0, 4'b1000, 1'b1, 1'b0);
        chk("dn_y", 32'(bus.y), 'h81);
        chk("dn_ram_lsb_o", 32'(bus.ram_lsb_o), 1);
        chk("dn_shift_dn", 32'(bus.shift_dn), 1);
        op_check(RD_A, 6, 0, 0, 1'b0, 4'h0, 1'b1, 1'b0);
        chk("dn_ram6", 32'(bus.y), 'hC0);
        op_check(RD_Q, 0, 0, 0, 1'b0, 4'h0, 1'b1, 1'b0);
        chk("dn_q", 32'(bus.y), 'h01);

        op_check(LD_B, 0, 4, 'hFF, 1'b0, 4'h0, 1'b1, 1'b0);
        op_check(LD_Q, 0, 0, 'hFF, 1'b0, 4'h0, 1'b1, 1'b0);
        op_check(RD_A, 4, 5, 0, 1'b0, 4'h0, 1'b1, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            op_check((c % 2 == 1) ? LD_B : LD_Q, 0, 7, 'h33, 1'b0, 4'h0, 1'b1, 1'b1);
            chk("mul_busy", 32'(bus.busy), 1);
            chk("mul_nodone", 32'(bus.done), 0);
        end
        op_check(RD_A, 5, 0, 0, 1'b0, 4'h0, 1'b1, 1'b0);
        chk("mul_idle", 32'(bus.busy), 0);
        chk("mul_done", 32'(bus.done), 1);
        chk("mul_hi", 32'(bus.y), 'hFE);
        op_check(RD_Q, 0, 0, 0, 1'b0, 4'h0, 1'b1, 1'b0);
        chk("mul_done_pulse", 32'(bus.done), 0);
        chk("mul_lo", 32'(bus.y), 'h01);
        op_check(RD_A, 7, 0, 0, 1'b0, 4'h0, 1'b1, 1'b0);
        chk("mul_blocked_wr", 32'(bus.y), 0);

        op_check(LD_Q, 0, 0, 'hFF, 1'b0, 4'h0, 1'b1, 1'b0);
        op_check(RD_A, 4, 5, 0, 1'b0, 4'h0, 1'b1, 1'b1);
        op_check(RD_Q, 0, 0, 0, 1'b0, 4'h0, 1'b1, 1'b0);
        op_check(RD_Q, 0, 0, 0, 1'b0, 4'h0, 1'b1, 1'b0);
        @(negedge cp);
        rst_lo = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_done", 32'(bus.done), 0);
        model_reset();
        @(negedge cp);
        rst_lo = 1'b1;
        repeat (10) op_check(RD_Q, 0, 0, 0, 1'b0, 4'h0, 1'b1, 1'b0);
        chk("abort_q", 32'(bus.y), 0);
        op_check(RD_A, 5, 0, 0, 1'b0, 4'h0, 1'b1, 1'b0);
        chk("abort_ram5", 32'(bus.y), 0);

        repeat (150) begin
            op_check(9'($urandom_range(0, 511)), $urandom_range(0, 15), $urandom_range(0, 15),
                     $urandom_range(0, 255), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     ($urandom_range(0, 3) != 0), 1'b0);
        end

        repeat (5) begin
            ra = $urandom_range(0, 15);
            rb = $urandom_range(0, 15);
            op_check(LD_B, 0, ra, $urandom_range(0, 255), 1'b0, 4'h0, 1'b1, 1'b0);
            op_check(LD_Q, 0, 0, $urandom_range(0, 255), 1'b0, 4'h0, 1'b1, 1'b0);
            op_check(LD_B, ra, ra, $urandom_range(0, 255), 1'b0, 4'h0, 1'b1, 1'b1);
            for (int k = 0; k < 9; k++) begin
                op_check(9'($urandom_range(0, 511)), $urandom_range(0, 15), $urandom_range(0, 15),
                         $urandom_range(0, 255), 1'($urandom_range(0, 1)),
                         4'($urandom_range(0, 15)), 1'b1,
                         (k < 8) ? 1'($urandom_range(0, 1)) : 1'b0);
            end
            op_check(RD_A, ra, rb, 0, 1'b0, 4'h0, 1'b1, 1'b0);
            op_check(RD_A, rb, ra, 0, 1'b0, 4'h0, 1'b1, 1'b0);
            op_check(RD_Q, 0, 0, 0, 1'b0, 4'h0, 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/am2901_wide.md
# am2901_wide

Parametrised successor of the 4-bit Am2901 slice: a WIDTH-bit bit-slice ALU with DEPTH-entry two-port register file, Q register, RAM/Q shifters and carry-lookahead outputs, executing the standard 9-bit Am2901 microinstruction. It adds a built-in multi-cycle unsigned multiply sequencer with a start/busy/done handshake. It sits in the same position as the original slice: fed by an external microsequencer, chained with neighbouring slices through the shift and lookahead pins.

## Interface
- WIDTH, 8, datapath width in bits (≥4)
- DEPTH, 16, register file entries (power of 2)
- AW, $clog2(DEPTH), register address width (derived)

- cp  in  1  clock, rising edge
- rst_lo  in  1  asynchronous, active-low reset
- i  in  9  microinstruction: i[2:0] source, i[5:3] function, i[8:6] destination
- a, b  in  AW  register addresses (A read; B read/write)
- d  in  WIDTH  direct data input
- cin  in  1  ALU carry-in
- oe  in  1  y output enable (1 = drive, 0 = y forced to 0)
- y  out  WIDTH  data output
- cout  out  1  ALU carry-out (carry from bit WIDTH-1)
- g_lo, p_lo  out  1  active-low group generate / propagate
- ovr  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB
- z  out  1  1 when F == 0
- fmsb  out  1  F[WIDTH-1]
- ram_lsb_i, ram_msb_i, q_lsb_i, q_msb_i  in  1  shift fill bits from neighbours
- ram_lsb_o, ram_msb_o, q_lsb_o, q_msb_o  out  1  F[0], F[WIDTH-1], Q[0], Q[WIDTH-1]
- shift_dn, shift_up  out  1  destination is 4/5 resp. 6/7 (neighbour tristate control)
- start  in  1  begin multiply (sampled only when idle)
- busy  out  1  multiply in progress
- done  out  1  one-cycle pulse: product written

## Operation
- Sources (R,S): 0 A,Q; 1 A,B; 2 0,Q; 3 0,B; 4 0,A; 5 D,A; 6 D,Q; 7 D,0.
- Functions: 0 R+S+cin; 1 S+~R+cin; 2 R+~S+cin; 3 R|S; 4 R&S; 5 ~R&S; 6 R^S; 7 ~(R^S). Logic ops: cout=0, ovr=0, g_lo/p_lo per standard Am2901 logic-op definitions.
- Destinations: 0 Q←F, y=F; 1 none, y=F; 2 B←F, y=A; 3 B←F, y=F; 4 B←F>>1 (MSB=ram_msb_i), Q←Q>>1 (MSB=q_msb_i), y=F; 5 B←F>>1, y=F; 6 B←F<<1 (LSB=ram_lsb_i), Q←Q<<1 (LSB=q_lsb_i), y=F; 7 B←F<<1, y=F.
- Register file read asynchronously; A and B reads both see pre-edge contents.
- FSM: IDLE → MUL on start; MUL holds WIDTH cycles → IDLE with done. At start: latch b, mcand←RAM[a], mq←Q, acc←0. Each MUL cycle: if mq[0] acc←acc+mcand (WIDTH+1 bits); {acc,mq}←{acc,mq}>>1. On final MUL edge: RAM[b_latched]←high WIDTH bits, Q←low WIDTH bits.
- While busy: instruction writes to RAM and Q suppressed; combinational outputs still follow i. start while busy ignored.

## Timing
- All state updates on rising cp; all outputs combinational from current state and inputs.
- Reset: RAM and Q cleared to 0, FSM IDLE, busy=0, done=0; other outputs follow reset-state contents.
- start high at edge k (IDLE): busy=1 after k through k+WIDTH; done=1 for exactly the cycle after edge k+WIDTH; a new start accepted at edge k+WIDTH+1 (same cycle as done).
- Instruction write at edge k and start at edge k: instruction write happens; multiply captures pre-edge operands.
- Reset mid-multiply: aborts; no partial product written.

## Structure
- am2901_pkg: source/function/destination enums, decode constants.
- Sub-module am2901_alu: combinational WIDTH-bit ALU producing F, cout, ovr, g_lo, p_lo.
- Top holds register file, Q, shifters, multiply FSM.

## Test plan
- WIDTH=8: d=0x5A, i=dest3/ADD/src DZ(7), cin=0, b=3 → RAM[3]=0x5A, y=0x5A, z=0.
- RAM[1]=0x7F, RAM[2]=0x01, src AB, ADD, cin=0 → F=0x80, ovr=1, cout=0, fmsb=1; SUB(1) of equal values, cin=1 → z=1, cout=1.
- dest 4, F=0x81, ram_msb_i=1, Q=0x02, q_msb_i=0 → RAM[b]=0xC0, Q=0x01, ram_lsb_o=1, shift_dn=1.
- RAM[4]=0xFF, Q=0xFF, start, a=4, b=5 → busy 8 cycles, done on 9th cycle, RAM[5]=0xFE, Q=0x01; instruction writes during busy have no effect.
- Assert rst_lo low at cycle 3 of multiply → busy=0, done never pulses, RAM[5]=0, Q=0.
